// File: rtl/seg7_pwm_mux.sv
// seg7_pwm_mux: N-digit multiplexed seven-segment driver with per-digit PWM brightness, blink and blanking
// ports: clk; reset_n async active-low; hex[4*DIGITS], dp/blank/blink[DIGITS], duty[PWM_BITS*DIGITS] per-digit inputs;
//        en[DIGITS] digit enables and ss[7:0] {dp,g..a} segments, both active-low and registered
module seg7_pwm_mux #(
    parameter int DIGITS       = 3,
    parameter int REFRESH_BITS = 16,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_BITS   = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [4*DIGITS-1:0]        hex,
    input  logic [DIGITS-1:0]          dp,
    input  logic [DIGITS-1:0]          blank,
    input  logic [DIGITS-1:0]          blink,
    input  logic [PWM_BITS*DIGITS-1:0] duty,
    output logic [DIGITS-1:0]          en,
    output logic [7:0]                 ss
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [REFRESH_BITS-1:0]    dwell;
    logic [IW-1:0]              idx;
    logic [PWM_BITS-1:0]        pwm;
    logic [BLINK_BITS-1:0]      blk;
    logic                       fresh;
    logic [4*DIGITS-1:0]        sh_hex;
    logic [DIGITS-1:0]          sh_dp, sh_blank, sh_blink;
    logic [PWM_BITS*DIGITS-1:0] sh_duty;
    logic                       dwell_end, idx_last, frame_end, pwm_on, lit;
    logic [4*DIGITS-1:0]        v_hex;
    logic [DIGITS-1:0]          v_dp, v_blank, v_blink;
    logic [PWM_BITS*DIGITS-1:0] v_duty;
    logic [3:0]                 cur_hex;
    logic [PWM_BITS-1:0]        cur_duty;
    logic [DIGITS-1:0]          en_n;
    logic [7:0]                 ss_n;
    // the first cycle after reset release displays the values being captured, so digit 0 gets a full dwell
    always_comb begin
        dwell_end = &dwell;
        idx_last  = idx == IW'(DIGITS - 1);
        frame_end = dwell_end & idx_last;
        v_hex     = fresh ? hex : sh_hex;
        v_dp      = fresh ? dp : sh_dp;
        v_blank   = fresh ? blank : sh_blank;
        v_blink   = fresh ? blink : sh_blink;
        v_duty    = fresh ? duty : sh_duty;
        cur_hex   = v_hex[idx*4 +: 4];
        cur_duty  = v_duty[idx*PWM_BITS +: PWM_BITS];
        pwm_on    = (&cur_duty) | (cur_duty > pwm);
        lit       = pwm_on & ~v_blank[idx] & ~(v_blink[idx] & blk[BLINK_BITS-1]) & ~dwell_end;
        en_n      = lit ? ~(DIGITS'(1) << idx) : '1;
        ss_n      = lit ? {~v_dp[idx], SEG[cur_hex]} : 8'hFF;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell    <= '0;
            idx      <= '0;
            pwm      <= '0;
            blk      <= '0;
            fresh    <= 1'b1;
            sh_hex   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_blink <= '0;
            sh_duty  <= '0;
            en       <= '1;
            ss       <= 8'hFF;
        end else begin
            dwell <= dwell + REFRESH_BITS'(1);
            pwm   <= pwm + PWM_BITS'(1);
            blk   <= blk + BLINK_BITS'(1);
            fresh <= 1'b0;
            if (dwell_end) idx <= idx_last ? '0 : idx + IW'(1);
            if (fresh | frame_end) begin
                sh_hex   <= hex;
                sh_dp    <= dp;
                sh_blank <= blank;
                sh_blink <= blink;
                sh_duty  <= duty;
            end
            en <= en_n;
            ss <= ss_n;
        end
    end
endmodule

// File: tb/tb_seg7_pwm_mux.sv
// tb_seg7_pwm_mux: scoreboard bench for seg7_pwm_mux against a cycle-count reference model
module tb_seg7_pwm_mux;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] hex = '0;
    logic [2:0]  dp = '0, blank = '0, blink = '0;
    logic [5:0]  duty = '0;
    logic [2:0]  en;
    logic [7:0]  ss;
    int          total = 0, bad = 0;
    int          k = 0;
    logic [10:0] q [$];
    logic [6:0]  seg_t [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [11:0] sh_hex;
    logic [2:0]  sh_dp, sh_blank, sh_blink;
    logic [5:0]  sh_duty;

    seg7_pwm_mux #(.DIGITS(3), .REFRESH_BITS(3), .PWM_BITS(2), .BLINK_BITS(6)) dut (
        .clk(clk), .reset_n(reset_n), .hex(hex), .dp(dp), .blank(blank),
        .blink(blink), .duty(duty), .en(en), .ss(ss)
    );

    always #5 clk = ~clk;

    task automatic sample();
        sh_hex = hex; sh_dp = dp; sh_blank = blank; sh_blink = blink; sh_duty = duty;
    endtask

    // k counts clock edges since reset release; every counter and the digit index derive from it
    always @(posedge clk) begin
        if (!reset_n) k = 0;
        else begin
            int d, dw, pw;
            logic [1:0] du;
            logic on;
            if (k == 0) sample();
            dw = k % 8;
            d  = (k / 8) % 3;
            pw = k % 4;
            du = sh_duty[d*2 +: 2];
            on = (du == 2'b11 || int'(du) > pw) && !sh_blank[d] &&
                 !(sh_blink[d] && (k % 64) >= 32) && dw != 7;
            q.push_back(on ? {3'b111 & ~(3'b001 << d), ~sh_dp[d], seg_t[sh_hex[d*4 +: 4]]} : {3'b111, 8'hFF});
            if (k % 24 == 23) sample();
            k++;
        end
    end

    always @(negedge clk) begin
        logic [10:0] e;
        if (!reset_n) begin
            total++;
            if (en !== 3'b111 || ss !== 8'hFF) begin
                bad++;
                $display("FAIL reset_state en=%b ss=%h want en=111 ss=ff", en, ss);
            end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ({en, ss} !== e) begin
                bad++;
                $display("FAIL scan k=%0d en=%b ss=%h want en=%b ss=%h", k - 1, en, ss, e[10:8], e[7:0]);
            end
        end
        total++;
        if ($countones(~en) > 1) begin
            bad++;
            $display("FAIL one_hot en=%b want at most one zero", en);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        hex = 12'h0F8; duty = 6'b111111;
        cyc(4);
        reset_n = 1'b1;
        cyc(60);
        duty = 6'b111101;
        cyc(60);
        duty = 6'b111100;
        cyc(50);
        duty = 6'b111111; blink = 3'b010; blank = 3'b100;
        cyc(150);
        blink = '0; blank = '0; hex = 12'h123;
        cyc(30);
        for (int i = 0; i < 30 && !(k % 24 >= 9 && k % 24 <= 14); i++) cyc(1);
        hex = 12'h456;
        cyc(60);
        for (int i = 0; i < 8; i++) begin
            hex = 12'($urandom); dp = 3'($urandom); blank = 3'($urandom);
            blink = 3'($urandom); duty = 6'($urandom);
            cyc($urandom_range(5, 40));
        end
        hex = 12'h0F8; dp = '0; blank = '0; blink = '0; duty = 6'b111111;
        begin
            int n = 0;
            while (en !== 3'b101 && n < 80) begin cyc(1); n++; end
            total++;
            if (en !== 3'b101) begin
                bad++;
                $display("FAIL wait_digit1 en=%b want 101", en);
            end
        end
        reset_n = 1'b0;
        q.delete();
        #1;
        total++;
        if (en !== 3'b111 || ss !== 8'hFF) begin
            bad++;
            $display("FAIL async_reset en=%b ss=%h want en=111 ss=ff", en, ss);
        end
        cyc(3);
        reset_n = 1'b1;
        cyc(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
